// File: rtl/wb_depp_arbiter.sv
// Two-master pipelined Wishbone arbiter: DEPP host bridge (A) and DSP engine (B) share one slave bus.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | no owner, slave bus quiet, both masters stalled
//  OWN_A  | master A holds the bus for its whole CYC
//  OWN_B  | master B holds the bus for its whole CYC
module wb_depp_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [DW-1:0] o_m_data,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,
    output logic [1:0]    o_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   last_b, last_b_nxt;
    logic   timeout;

`ifdef WB_ARB_TIMEOUT_EN
    // Down-counter reloaded while idle and on any slave response; zero while owned is a hang.
    localparam logic [7:0] WD_LOAD = 8'(TO_CYC - 1);
    logic [7:0] wdog;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog <= WD_LOAD;
        end else if (state == IDLE || i_wb_ack || i_wb_err) begin
            wdog <= WD_LOAD;
        end else if (wdog != 8'd0) begin
            wdog <= wdog - 8'd1;
        end
    end

    assign timeout = (state != IDLE) && (wdog == 8'd0) && !i_wb_ack && !i_wb_err;
`else
    logic [7:0] unused_to_cyc;
    assign unused_to_cyc = 8'(TO_CYC);
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_b <= last_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        case (state)
            IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    state_nxt = last_b ? OWN_A : OWN_B;
                end else if (i_a_cyc) begin
                    state_nxt = OWN_A;
                end else if (i_b_cyc) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!i_a_cyc || timeout) begin
                    state_nxt  = IDLE;
                    last_b_nxt = 1'b0;
                end
            end
            OWN_B: begin
                if (!i_b_cyc || timeout) begin
                    state_nxt  = IDLE;
                    last_b_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux and response steering follow the registered owner only.
    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_a_ack   = 1'b0;
        o_a_stall = 1'b1;
        o_a_err   = 1'b0;
        o_b_ack   = 1'b0;
        o_b_stall = 1'b1;
        o_b_err   = 1'b0;
        case (state)
            OWN_A: begin
                o_wb_cyc  = i_a_cyc & ~timeout;
                o_wb_stb  = i_a_stb & ~timeout;
                o_wb_we   = i_a_we;
                o_wb_addr = i_a_addr;
                o_wb_data = i_a_data;
                o_a_ack   = i_wb_ack;
                o_a_stall = i_wb_stall;
                o_a_err   = i_wb_err | timeout;
            end
            OWN_B: begin
                o_wb_cyc  = i_b_cyc & ~timeout;
                o_wb_stb  = i_b_stb & ~timeout;
                o_wb_we   = i_b_we;
                o_wb_addr = i_b_addr;
                o_wb_data = i_b_data;
                o_b_ack   = i_wb_ack;
                o_b_stall = i_wb_stall;
                o_b_err   = i_wb_err | timeout;
            end
            default: ;
        endcase
    end

    assign o_m_data = i_wb_data;
    assign o_owner  = state;

endmodule
